// File: rtl/blk_23973d.sv
`default_nettype none
// ============================================================================
// Module   : blk_23973d
// Brief    : WIDTH-bit D-type register with asynchronous active-high reset
//            to RST_VAL and a complemented output Qn.
// Revision : 1.0 - initial release
// ============================================================================
module blk_23973d #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clck,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // Single storage element; every bit shares the same edge and reset.
  logic [WIDTH-1:0] r_q;

  // Capture D on the rising edge; reset forces RST_VAL without waiting for a clock.
  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= D;
    end
  end

  // Qn is derived from the stored value only, so it tracks Q through reset too.
  assign Q  = r_q;
  assign Qn = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_blk_23973d.sv
`default_nettype none
// ============================================================================
// Module   : tb_blk_23973d
// Brief    : Directed self-checking bench for blk_23973d (1-bit default and
//            8-bit instance with RST_VAL = 8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_blk_23973d;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d1;
  logic       q1;
  logic       qn1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qn8;
  logic       mon_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  // 6 ns period: rising edges at 3, 9, 15, ...
  always #3 clk = ~clk;

  blk_23973d u_dut1 (
    .Clck  (clk),
    .Reset (rst),
    .D     (d1),
    .Q     (q1),
    .Qn    (qn1)
  );

  blk_23973d #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dut8 (
    .Clck  (clk),
    .Reset (rst),
    .D     (d8),
    .Q     (q8),
    .Qn    (qn8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Continuous complement check one ns after every rising edge.
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      chk("qn1_compl", {63'd0, qn1}, {63'd0, {~q1}});
      chk("qn8_compl", {56'd0, qn8}, {56'd0, {~q8}});
    end
  end

  initial begin
    logic [5:0] exp_seq;
    d1 = 1'b0;
    d8 = 8'h3C;

    // Reset asserted between edges, before any clock edge: immediate effect.
    #1 rst = 1'b1;
    #1;
    chk("rst_q1",  {63'd0, q1},  64'd0);
    chk("rst_qn1", {63'd0, qn1}, 64'd1);
    chk("rst_q8",  {56'd0, q8},  64'hA5);
    chk("rst_qn8", {56'd0, qn8}, 64'h5A);

    // Edges held in reset are ignored even with D = 1.
    d1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_q1", {63'd0, q1}, 64'd0);
      chk("hold_q8", {56'd0, q8}, 64'hA5);
    end

    // First edge after release loads D.
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_q1",  {63'd0, q1},  64'd1);
    chk("rel_qn1", {63'd0, qn1}, 64'd0);
    chk("rel_q8",  {56'd0, q8},  64'h3C);
    chk("rel_qn8", {56'd0, qn8}, 64'hC3);
    mon_en = 1'b1;

    d8 = 8'h81;
    @(posedge clk); #1;
    chk("w8_q8",  {56'd0, q8},  64'h81);
    chk("w8_qn8", {56'd0, qn8}, 64'h7E);

    // D toggles every 5 ns from an edge; edge at +30 coincides with a toggle
    // and must see the pre-toggle value 1. Expected Q: 1,0,1,0,1,0.
    exp_seq = 6'b010101;
    @(posedge clk);
    d1 <= 1'b0;
    fork
      begin
        repeat (6) begin
          #5 d1 <= ~d1;
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          chk($sformatf("tog_q1_%0d", i), {63'd0, q1}, {63'd0, exp_seq[i]});
        end
      end
    join

    // Short pulse entirely between edges is not captured.
    d1 = 1'b1;
    #2 d1 = 1'b0;
    chk("glitch_mid", {63'd0, q1}, 64'd0);
    @(posedge clk); #1;
    chk("glitch_edge", {63'd0, q1}, 64'd0);

    // Reset mid-operation acts immediately.
    d1 = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_q1", {63'd0, q1}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q1",  {63'd0, q1},  64'd0);
    chk("mid_rst_qn1", {63'd0, qn1}, 64'd1);
    chk("mid_rst_q8",  {56'd0, q8},  64'hA5);
    @(posedge clk); #1;
    chk("mid_hold_q1", {63'd0, q1}, 64'd0);

    // Deassertion coincident with an edge: that edge still counts as reset.
    @(posedge clk);
    rst <= 1'b0;
    #1;
    chk("coinc_q1", {63'd0, q1}, 64'd0);
    @(posedge clk); #1;
    chk("after_coinc_q1", {63'd0, q1}, 64'd1);
    chk("after_coinc_q8", {56'd0, q8}, 64'h81);

    // Let the complement monitor run for a further stretch.
    repeat (10) @(posedge clk);
    #2;
    mon_en = 1'b0;
    #10;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
